data_mem_ctrl: RTL

Clocked, parametrised data memory for the MIPS datapath, serving the MEM stage with byte/halfword/word loads and stores. Adds byte-lane write enables, sign/zero extension, alignment and range checking, and a fixed, configurable wait-state latency behind a valid/ready request and single-cycle response handshake. The MEM-stage stall logic uses `req_ready` and `rsp_valid` to hold the pipeline.

---
 rtl/dmem_pkg.sv | 74 +++++++
 rtl/data_mem_ctrl_array.sv | 28 ++
 rtl/data_mem_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       sgn;
  } req_op_t;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] a
  );
    case (size)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic bad_align(
    input logic [1:0] size,
    input logic [1:0] a
  );
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      SZ_WORD: return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // Replicate narrow store data so any enabled lane sees it.
  function automatic logic [31:0] store_align(
    input logic [31:0] w,
    input logic [1:0]  size
  );
    case (size)
      SZ_BYTE: return {4{w[7:0]}};
      SZ_HALF: return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [1:0]  size,
    input logic [1:0]  a,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: return {{24{sgn & b[7]}}, b};
      SZ_HALF: return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_array.sv
// Word-wide synchronous RAM with byte-lane write enables.
module dmem_array #(
  parameter int DEPTH = 128,
  parameter int IW    = 7
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we && be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: request latch, wait states, fault check
// and load extension around a byte-enabled RAM.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  req_op_t           acc_op;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_fault;
  logic              accept;
  logic              ram_en;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  assign accept =
    (state_q == S_IDLE) && req_ready_q && req_valid;

  // In IDLE the access runs straight off the inputs so a
  // zero-wait request can commit on the accepting edge.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_op    = '{write: req_write,
                    size:  req_size,
                    sgn:   req_signed};
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_op    = op_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_fault =
    bad_align(acc_op.size, acc_addr[1:0]) ||
    (32'(acc_addr[ADDR_W-1:2]) >= 32'(DEPTH));

  assign ram_en = (state_d == S_RESP);
  assign ram_we = ram_en && acc_op.write && !acc_fault;

  dmem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (lane_mask(acc_op.size, acc_addr[1:0])),
    .addr  (acc_addr[IW+1:2]),
    .wdata (store_align(acc_wdata, acc_op.size)),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = acc_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      S_RESP: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = acc_fault;
        if (!acc_op.write && !acc_fault) begin
          rsp_rdata_d = load_ext(ram_rdata, acc_op.size,
                                 acc_addr[1:0], acc_op.sgn);
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
